led_seg_out: RTL
================

// Module: led_seg_out
// PURPOSE
//  Memory-mapped output peripheral: the write-side counterpart of the switch input port.
//  Holds CPU-written LED and 7-segment data in registers, drives 24 LEDs and time-multiplexes
//  8 hex digits onto a common-anode 7-seg display. Sits behind the memOrIO decoder on the
//  ioWrite path, selected by LEDCtrl/SegCtrl.
// PARAMETERS
//  SCAN_DIV   100000      clock cycles per digit slot (100 MHz -> 1 kHz digit rate); >=2
//  BLINK_DIV  50000000    clock cycles per LED blink half-period (LED_BLINK_EN only); >=2
// PORTS
//  clock       in   1   system clock, all state on posedge
//  reset       in   1   asynchronous, active-low reset (0 = reset)
//  LEDCtrl     in   1   LED register block selected by address decoder
//  SegCtrl     in   1   7-seg register block selected by address decoder
//  ioWrite     in   1   CPU store strobe, one cycle per store
//  addr_low    in   2   address bits [1:0] of the store
//  write_data  in   16  store data
//  leds        out  24  LED drive, 1 = on
//  seg_en      out  8   digit enables, active-low, one-hot-zero
//  seg_out     out  8   segments {dp,g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  - Registers: led_reg[23:0], seg_reg[31:0] (digit i = seg_reg[4i+3:4i]), pre_cnt, dig_idx[2:0].
//  - Reset (reset=0, async): led_reg=0, seg_reg=0, pre_cnt=0, dig_idx=0 -> leds=24'h0,
//    seg_en=8'hFE, seg_out=8'hC0. Takes effect immediately, including mid-scan/mid-write.
//  - LED write: ioWrite&&LEDCtrl at posedge: addr_low=00 -> led_reg[15:0]<=write_data;
//    addr_low=10 -> led_reg[23:16]<=write_data[7:0]; 01/11 ignored (see CONFIGURATION).
//  - Seg write: ioWrite&&SegCtrl: 00 -> seg_reg[15:0]; 10 -> seg_reg[31:16]; 01/11 ignored.
//  - LEDCtrl and SegCtrl both high: both writes happen. ioWrite=0: no register changes.
//  - Latency: written value visible on leds one edge after the strobe; on seg_out when the
//    digit is next scanned (at most 8*SCAN_DIV cycles).
//  - Scanner: pre_cnt counts 0..SCAN_DIV-1 then wraps to 0; on wrap dig_idx increments,
//    7 wraps to 0. Scanner free-runs, unaffected by writes.
//  - seg_en = ~(8'b1 << dig_idx); seg_out = hexdecode(digit dig_idx) with dp=1 (off).
//    Decode table (active-low): 0 C0,1 F9,2 A4,3 B0,4 99,5 92,6 82,7 F8,8 80,9 90,
//    A 88,B 83,C C6,D A1,E 86,F 8E. Outputs are combinational from registered state only.
// CONFIGURATION
//  LED_BLINK_EN defined: extra blink_on bit (reset 0) and blink counter/phase (reset 0,
//    phase=1 = visible). LED write addr_low=01 -> blink_on<=write_data[0]. Phase toggles
//    every BLINK_DIV cycles; leds = (blink_on && !phase) ? 24'h0 : led_reg. Clearing
//    blink_on shows led_reg on the next edge.
//  LED_BLINK_EN undefined: no blink logic; addr 01 writes ignored; leds = led_reg.
// STRUCTURE
//  - Package io_out_pkg: address offsets (OFF_LO=2'b00, OFF_BLINK=2'b01, OFF_HI=2'b10),
//    SEG_BLANK=8'hFF, 16-entry hex-to-segment constant table.
//  - Sub-module seg_hex_decode (4-bit in, 8-bit active-low out, combinational); scanner,
//    prescaler and registers stay in led_seg_out.
// TESTING (bench uses SCAN_DIV=4, BLINK_DIV=8)
//  1. reset=0 mid-run -> leds=0, seg_en=FE, seg_out=C0 immediately, without waiting for an edge.
//  2. LEDCtrl=1,ioWrite=1,addr=00,data=A5A5 then addr=10,data=12FF -> leds=24'hFFA5A5.
//  3. LEDCtrl=1,ioWrite=0,data=FFFF; and LEDCtrl=0,ioWrite=1 -> leds unchanged.
//  4. SegCtrl writes 00:3210, 10:7654 -> dig 0..7 show C0,F9,A4,B0,99,92,82,F8; each slot
//     4 cycles; dig_idx 7->0 after 32 cycles.
//  5. Both Ctrl high, addr=00, data=0008 -> leds[15:0]=0008 and digit0 shows 80.
//  6. LED_BLINK_EN: leds=0000FF, write addr 01 data=1 -> leds alternates FF/00 every 8
//     cycles; write data=0 -> steady FF.

Source files
------------

// File: rtl/io_out_pkg.sv
// rtl/io_out_pkg.sv - shared constants for the LED / 7-segment output peripheral
// Purpose: register offsets within each block, blank pattern and the hex-to-segment table.
// Ports: none (package).
package io_out_pkg;

  // Store offsets (addr_low) inside the LED and 7-seg register blocks; 2'b11 is unmapped.
  typedef enum logic [1:0] {
    OFF_LO    = 2'b00,
    OFF_BLINK = 2'b01,
    OFF_HI    = 2'b10
  } io_off_e;

  // All segments dark (active-low), including the decimal point.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a} patterns; element i shows hex digit i.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational hex digit to active-low 7-segment pattern
// Purpose: map one 4-bit nibble onto the common-anode segment lines.
// Ports:
//   digit_i  in  4  hex value to display
//   seg_o    out 8  {dp,g,f,e,d,c,b,a}, active-low, dp always off
module seg_hex_decode
  import io_out_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [7:0] seg_o
);

  // dp bit is taken from the blank pattern so the point can never light.
  assign seg_o = SEG_TABLE[digit_i] | (SEG_BLANK & 8'h80);

endmodule

// File: rtl/led_seg_out.sv
// rtl/led_seg_out.sv - memory-mapped LED register and multiplexed 8-digit 7-seg driver
// Purpose: holds CPU-written LED and hex display data and scans the digits one at a time.
// Optional feature: define LED_BLINK_EN to add a software-controlled LED blink.
// Ports:
//   clock       in  1   system clock
//   reset       in  1   asynchronous active-low reset
//   LEDCtrl     in  1   LED register block selected
//   SegCtrl     in  1   7-seg register block selected
//   ioWrite     in  1   store strobe
//   addr_low    in  2   store address bits [1:0]
//   write_data  in  16  store data
//   leds        out 24  LED drive, 1 = on
//   seg_en      out 8   digit enables, active-low
//   seg_out     out 8   segments {dp,g,f,e,d,c,b,a}, active-low
module led_seg_out
  import io_out_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        LEDCtrl,
  input  logic        SegCtrl,
  input  logic        ioWrite,
  input  logic [1:0]  addr_low,
  input  logic [15:0] write_data,
  output logic [23:0] leds,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out
);

  if (SCAN_DIV < 2 || BLINK_DIV < 2) begin : g_param_check
    $error("led_seg_out: SCAN_DIV and BLINK_DIV must be at least 2");
  end

  localparam int SCAN_W = $clog2(SCAN_DIV);

  logic [23:0]       led_q, led_d;
  logic [31:0]       seg_q, seg_d;
  logic [SCAN_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [2:0]        dig_idx_q, dig_idx_d;
  logic              led_wr, seg_wr, scan_wrap;
  logic [3:0]        cur_digit;

`ifdef LED_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_DIV);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic               blink_on_q, blink_on_d;
`endif

  assign led_wr    = ioWrite && LEDCtrl;
  assign seg_wr    = ioWrite && SegCtrl;
  assign scan_wrap = (pre_cnt_q == SCAN_W'(SCAN_DIV - 1));

  always_comb begin
    led_d     = led_q;
    seg_d     = seg_q;
    pre_cnt_d = scan_wrap ? '0 : pre_cnt_q + 1'b1;
    // 3-bit index rolls 7 -> 0 on its own.
    dig_idx_d = scan_wrap ? dig_idx_q + 3'd1 : dig_idx_q;

    if (led_wr) begin
      case (addr_low)
        OFF_LO:  led_d[15:0]  = write_data;
        OFF_HI:  led_d[23:16] = write_data[7:0];
        default: ;
      endcase
    end

    if (seg_wr) begin
      case (addr_low)
        OFF_LO:  seg_d[15:0]  = write_data;
        OFF_HI:  seg_d[31:16] = write_data;
        default: ;
      endcase
    end
  end

`ifdef LED_BLINK_EN
  always_comb begin
    blink_on_d  = blink_on_q;
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
    if (led_wr && addr_low == OFF_BLINK) begin
      blink_on_d = write_data[0];
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led_q       <= '0;
      seg_q       <= '0;
      pre_cnt_q   <= '0;
      dig_idx_q   <= '0;
`ifdef LED_BLINK_EN
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      blink_on_q  <= 1'b0;
`endif
    end else begin
      led_q       <= led_d;
      seg_q       <= seg_d;
      pre_cnt_q   <= pre_cnt_d;
      dig_idx_q   <= dig_idx_d;
`ifdef LED_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      blink_on_q  <= blink_on_d;
`endif
    end
  end

  // Phase 0 is the dark half of the blink period.
`ifdef LED_BLINK_EN
  assign leds = (blink_on_q && !phase_q) ? 24'h0 : led_q;
`else
  assign leds = led_q;
`endif

  assign seg_en    = ~(8'b1 << dig_idx_q);
  assign cur_digit = seg_q[{dig_idx_q, 2'b00} +: 4];

  seg_hex_decode u_dec (
    .digit_i (cur_digit),
    .seg_o   (seg_out)
  );

endmodule
